// File: rtl/bfsk_symbol_framer.sv
// bfsk_symbol_framer
// Upstream stage of the BFSK modulator. Bytes arrive over a valid/ready
// stream into a one-deep holding register. For each frame the framer
// pulses `start`, waits out the modulator sync interval, then sends a fixed
// preamble followed by the payload MSB-first. Each bit is held for
// SAMPLES_PER_SYMBOL clocks. The frame is closed by a guard interval of
// zeros.
//
// Ports:
//   clk        in  1  clock
//   reset      in  1  synchronous, active-high reset
//   s_data     in  8  payload byte
//   s_last     in  1  final byte of the frame
//   s_valid    in  1  byte valid
//   s_ready    out 1  holding register empty (combinational)
//   start      out 1  one-cycle frame start pulse to the modulator
//   data_out   out 1  current symbol bit to the modulator
//   sym_strobe out 1  first cycle of every preamble/data symbol
//   busy       out 1  high whenever the framer is not idle
//   frame_done out 1  one-cycle pulse after the guard interval
//   underrun   out 1  one-cycle pulse when a frame is aborted for lack of data
module bfsk_symbol_framer #(
  parameter int          SAMPLES_PER_SYMBOL = 64,
  parameter int          SYNC_GAP           = 12,
  parameter int          PREAMBLE_BITS      = 8,
  parameter logic [15:0] PREAMBLE           = 16'hAAAA,
  parameter int          GUARD_SYMBOLS      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       start,
  output logic       data_out,
  output logic       sym_strobe,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int SW  = $clog2(SAMPLES_PER_SYMBOL);
  localparam int GW  = $clog2(SYNC_GAP + 1);
  localparam int GDW = $clog2(GUARD_SYMBOLS + 1);

  localparam logic [SW-1:0]  SAMP_LAST  = SW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [GW-1:0]  GAP_LAST   = GW'(SYNC_GAP - 1);
  localparam logic [3:0]     PRE_LAST   = 4'(PREAMBLE_BITS - 1);
  localparam logic [GDW-1:0] GUARD_LAST = GDW'(GUARD_SYMBOLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PREAMBLE,
    ST_DATA,
    ST_GUARD
  } state_t;

  state_t         state, state_next;

  logic [7:0]     hold_data;
  logic           hold_last;
  logic           hold_v;

  logic [7:0]     shift, shift_next;
  logic           shift_last, shift_last_next;

  logic [SW-1:0]  samp_cnt, samp_next;
  logic [3:0]     bit_cnt, bit_next;
  logic [GW-1:0]  gap_cnt, gap_next;
  logic [GDW-1:0] guard_cnt, guard_next;

  logic           load;
  logic           accept;
  logic           sym_end;
  logic           underrun_next;
  logic           start_next;
  logic           strobe_next;
  logic           data_next;
  logic           done_next;
  logic [3:0]     pre_idx;

  assign s_ready = !hold_v;
  assign accept  = s_valid && !hold_v;
  assign sym_end = (samp_cnt == SAMP_LAST);

  // Holding register. A new byte takes priority over the shift-register load
  // so a refill on the same edge keeps hold_v set.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v    <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else if (accept) begin
      hold_v    <= 1'b1;
      hold_data <= s_data;
      hold_last <= s_last;
    end else if (load) begin
      hold_v    <= 1'b0;
    end
  end

  // State, counters, shift register and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift      <= '0;
      shift_last <= 1'b0;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      guard_cnt  <= '0;
      start      <= 1'b0;
      data_out   <= 1'b0;
      sym_strobe <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      shift_last <= shift_last_next;
      samp_cnt   <= samp_next;
      bit_cnt    <= bit_next;
      gap_cnt    <= gap_next;
      guard_cnt  <= guard_next;
      start      <= start_next;
      data_out   <= data_next;
      sym_strobe <= strobe_next;
      busy       <= (state_next != ST_IDLE);
      frame_done <= done_next;
      underrun   <= underrun_next;
    end
  end

  // Next-state and counter logic. The sample counter only runs while symbols
  // are being timed; it is zero in IDLE and SYNC so every symbol phase starts
  // aligned.
  always_comb begin
    state_next      = state;
    shift_next      = shift;
    shift_last_next = shift_last;
    samp_next       = '0;
    bit_next        = bit_cnt;
    gap_next        = '0;
    guard_next      = '0;
    load            = 1'b0;
    underrun_next   = 1'b0;

    case (state)
      ST_IDLE: begin
        bit_next = '0;
        if (hold_v) state_next = ST_SYNC;
      end

      ST_SYNC: begin
        bit_next = '0;
        gap_next = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) begin
          gap_next = '0;
          if (hold_v) begin
            state_next = ST_PREAMBLE;
            load       = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_PREAMBLE: begin
        samp_next = sym_end ? '0 : samp_cnt + 1'b1;
        if (sym_end) begin
          if (bit_cnt == PRE_LAST) begin
            bit_next   = '0;
            state_next = ST_DATA;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end

      ST_DATA: begin
        samp_next = sym_end ? '0 : samp_cnt + 1'b1;
        if (sym_end) begin
          if (bit_cnt == 4'd7) begin
            bit_next = '0;
            if (shift_last) begin
              state_next = ST_GUARD;
            end else if (hold_v) begin
              load = 1'b1;
            end else begin
              state_next    = ST_IDLE;
              underrun_next = 1'b1;
            end
          end else begin
            bit_next   = bit_cnt + 1'b1;
            shift_next = {shift[6:0], 1'b0};
          end
        end
      end

      ST_GUARD: begin
        samp_next  = sym_end ? '0 : samp_cnt + 1'b1;
        guard_next = guard_cnt;
        if (sym_end) begin
          if (guard_cnt == GUARD_LAST) begin
            guard_next = '0;
            state_next = ST_IDLE;
          end else begin
            guard_next = guard_cnt + 1'b1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase

    if (load) begin
      shift_next      = hold_data;
      shift_last_next = hold_last;
    end
  end

  // Registered output values are computed from the upcoming state so that
  // data_out and sym_strobe line up with the first sample of each symbol.
  always_comb begin
    pre_idx     = 4'd15 - bit_next;
    start_next  = (state == ST_IDLE) && (state_next == ST_SYNC);
    done_next   = (state == ST_GUARD) && (state_next == ST_IDLE);
    strobe_next = ((state_next == ST_PREAMBLE) && ((state == ST_SYNC) || sym_end)) ||
                  ((state_next == ST_DATA) && sym_end);
    data_next   = 1'b0;
    case (state_next)
      ST_PREAMBLE: data_next = PREAMBLE[pre_idx];
      ST_DATA:     data_next = shift_next[7];
      default:     data_next = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bfsk_symbol_framer.sv
// Testbench for bfsk_symbol_framer. A monitor records every output once per
// cycle; each frame is then compared against a per-cycle reference computed
// from the frame timeline (sync gap, preamble, payload bits, guard).
module tb_bfsk_symbol_framer;

  localparam int          SPS  = 4;
  localparam int          GAP  = 3;
  localparam int          PB   = 4;
  localparam logic [15:0] PRE  = 16'hA000;
  localparam int          G    = 1;
  localparam int          MAXC = 16384;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic       start;
  logic       data_out;
  logic       sym_strobe;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  bfsk_symbol_framer #(
    .SAMPLES_PER_SYMBOL(SPS),
    .SYNC_GAP(GAP),
    .PREAMBLE_BITS(PB),
    .PREAMBLE(PRE),
    .GUARD_SYMBOLS(G)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_data(s_data),
    .s_last(s_last),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .start(start),
    .data_out(data_out),
    .sym_strobe(sym_strobe),
    .busy(busy),
    .frame_done(frame_done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Cycle index: sample k is the cycle following the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  bit tr_data  [MAXC];
  bit tr_strb  [MAXC];
  bit tr_busy  [MAXC];
  bit tr_start [MAXC];
  bit tr_done  [MAXC];
  bit tr_under [MAXC];
  bit tr_ready [MAXC];

  // Output recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      tr_data[cyc]  = data_out;
      tr_strb[cyc]  = sym_strobe;
      tr_busy[cyc]  = busy;
      tr_start[cyc] = start;
      tr_done[cyc]  = frame_done;
      tr_under[cyc] = underrun;
      tr_ready[cyc] = s_ready;
    end
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] pay[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents one byte starting at a falling edge and holds it until it is
  // taken. Returns the sample index of the cycle after the accepting edge.
  task automatic applyStimulus(input logic [7:0] d, input logic l, output int acc);
    int n;
    n = 0;
    acc = -1;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!s_ready && n < 800) begin
      @(negedge clk);
      n++;
    end
    if (s_ready) begin
      acc = cyc + 1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    checkOutput("accept_in_time", int'(acc >= 0), 1);
    if (acc < 0) acc = cyc;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Compares a whole frame beginning at sample s (the start pulse) against
  // the reference timeline built from the payload in `pay`.
  task automatic checkFrame(input string tag, input int s, input bit complete);
    int n_sym, lend, idx, j, b;
    int md, ms, mb, mst, mdn, mu;
    bit e_data, e_strb, e_busy, e_start, e_done, e_under;
    logic [15:0] pre;
    logic [7:0]  byt;
    pre   = PRE;
    n_sym = PB + 8 * pay.size();
    lend  = GAP + (n_sym + (complete ? G : 0)) * SPS;
    waitUntil(s + lend + 2);
    md = 0; ms = 0; mb = 0; mst = 0; mdn = 0; mu = 0;
    for (int k = 0; k <= lend; k++) begin
      idx    = s + k;
      e_data = 1'b0;
      e_strb = 1'b0;
      if (k >= GAP) begin
        j = (k - GAP) / SPS;
        if (j < PB) begin
          e_data = pre[15 - j];
        end else if (j < n_sym) begin
          b      = j - PB;
          byt    = pay[b / 8];
          e_data = byt[7 - (b % 8)];
        end
        e_strb = ((k - GAP) % SPS == 0) && (j < n_sym);
      end
      e_busy  = (k < lend);
      e_start = (k == 0);
      e_done  = complete && (k == lend);
      e_under = !complete && (k == lend);
      if (tr_data[idx]  !== e_data)  md++;
      if (tr_strb[idx]  !== e_strb)  ms++;
      if (tr_busy[idx]  !== e_busy)  mb++;
      if (tr_start[idx] !== e_start) mst++;
      if (tr_done[idx]  !== e_done)  mdn++;
      if (tr_under[idx] !== e_under) mu++;
    end
    checkOutput({tag, "_data_out_errs"}, md, 0);
    checkOutput({tag, "_sym_strobe_errs"}, ms, 0);
    checkOutput({tag, "_busy_errs"}, mb, 0);
    checkOutput({tag, "_start_errs"}, mst, 0);
    checkOutput({tag, "_frame_done_errs"}, mdn, 0);
    checkOutput({tag, "_underrun_errs"}, mu, 0);
  endtask

  initial begin
    int a0, a1, a2, n, s1, l1;
    logic [7:0] b0, b1;

    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;

    // Reset state after two reset edges
    repeat (2) @(negedge clk);
    checkOutput("rst_start", int'(start), 0);
    checkOutput("rst_data_out", int'(data_out), 0);
    checkOutput("rst_sym_strobe", int'(sym_strobe), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_underrun", int'(underrun), 0);
    checkOutput("rst_s_ready", int'(s_ready), 1);
    reset = 1'b0;
    @(negedge clk);

    // Single byte 0xC3
    pay = '{8'hC3};
    applyStimulus(8'hC3, 1'b1, a0);
    checkFrame("single", a0 + 1, 1'b1);
    checkOutput("single_done_at_e56", int'(tr_done[a0 + 56]), 1);
    checkOutput("single_start_one_cycle", int'(tr_start[a0 + 2]), 0);

    // Two bytes back-to-back
    pay = '{8'hFF, 8'h01};
    applyStimulus(8'hFF, 1'b0, a0);
    applyStimulus(8'h01, 1'b1, a1);
    checkFrame("b2b", a0 + 1, 1'b1);

    // Underrun after a non-final byte
    pay = '{8'h80};
    applyStimulus(8'h80, 1'b0, a0);
    checkFrame("underrun", a0 + 1, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("underrun_stays_idle", int'(busy), 0);

    // Backpressure: three bytes presented continuously
    pay.delete();
    for (int i = 0; i < 3; i++) pay.push_back(8'($urandom));
    applyStimulus(pay[0], 1'b0, a0);
    applyStimulus(pay[1], 1'b0, a1);
    applyStimulus(pay[2], 1'b1, a2);
    checkFrame("bp", a0 + 1, 1'b1);
    checkOutput("bp_ready_low_0", int'(tr_ready[a0]), 0);
    checkOutput("bp_ready_low_1", int'(tr_ready[a1]), 0);
    checkOutput("bp_ready_low_2", int'(tr_ready[a2]), 0);

    // Queued next frame: byte held when the guard ends
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    applyStimulus(b0, 1'b1, a0);
    applyStimulus(b1, 1'b1, a1);
    s1  = a0 + 1;
    l1  = GAP + (PB + 8 + G) * SPS;
    pay = '{b0};
    checkFrame("queued_a", s1, 1'b1);
    pay = '{b1};
    checkFrame("queued_b", s1 + l1 + 1, 1'b1);

    // Randomized frames of 1..3 bytes with short gaps between bytes
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, 3);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(pay[0], (n == 1), a0);
      for (int i = 1; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        applyStimulus(pay[i], (i == n - 1), a1);
      end
      checkFrame($sformatf("rand%0d", f), a0 + 1, 1'b1);
    end

    // Reset during DATA with a second byte held
    applyStimulus(8'hFF, 1'b1, a0);
    applyStimulus(8'h55, 1'b1, a1);
    waitUntil(a0 + 1 + GAP + PB * SPS + 5);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_data_out", int'(data_out), 0);
    checkOutput("midrst_s_ready", int'(s_ready), 1);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midrst_held_discarded", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bfsk_symbol_framer.md
# bfsk_symbol_framer

- Upstream stage of the BFSK modulator: accepts bytes over a valid/ready stream and drives the modulator's `start` and `data_in` inputs.
- Per frame, issues one `start` pulse, then waits out the modulator's sync interval.
- Then emits a fixed preamble followed by the payload, MSB-first, holding each bit for exactly `SAMPLES_PER_SYMBOL` clocks.
- Closes the frame with a guard interval of zeros.

## Interface
Parameters:
- `SAMPLES_PER_SYMBOL`, 64: clocks per transmitted bit (≥2).
- `SYNC_GAP`, 12: clocks from `start` assertion to the first preamble symbol (≥1). Covers the modulator sync interval.
- `PREAMBLE_BITS`, 8: preamble length in symbols (1..16).
- `PREAMBLE`, 16'hAAAA: preamble pattern. The top `PREAMBLE_BITS` bits are sent MSB-first.
- `GUARD_SYMBOLS`, 2: symbols of `data_out`=0 after the last payload bit (≥1).

Ports (one clock, `clk`; reset is synchronous and active-high, named `reset`):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `s_data` in 8: payload byte.
- `s_last` in 1: marks the final byte of a frame.
- `s_valid` in 1: byte valid.
- `s_ready` out 1: holding register empty.
- `start` out 1: one-cycle frame-start pulse; goes to modulator `start`.
- `data_out` out 1: current symbol bit; goes to modulator `data_in`.
- `sym_strobe` out 1: high on the first cycle of every preamble and data symbol.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when GUARD completes.
- `underrun` out 1: one-cycle pulse when a frame is aborted for lack of data.

## Operation
- **Holding register:** one byte plus its last flag, with valid bit `hold_v`.
  - `s_ready` = !`hold_v` (combinational).
  - A byte is accepted on a cycle with `s_valid`&&`s_ready`.
  - Acceptance is allowed in any state.
- **Shift register:** 8 bits plus `last` flag. Loaded from the holding register, which clears `hold_v`.
  - If the holding register is loaded and refilled on the same edge, the new byte wins and `hold_v` stays 1.
- **Counters:**
  - `samp_cnt` counts 0..`SAMPLES_PER_SYMBOL`-1 and wraps.
  - `bit_cnt` counts bits within the preamble (0..`PREAMBLE_BITS`-1) or within a byte (0..7).
  - `gap_cnt` counts SYNC clocks.
- **FSM states:** IDLE, SYNC, PREAMBLE, DATA, GUARD.
  - IDLE → SYNC when `hold_v`=1. `start`=1 for the first SYNC cycle only.
  - SYNC → PREAMBLE after `SYNC_GAP` cycles in SYNC. The holding byte is loaded into the shift register on this same edge.
    - If `hold_v`=0 at that edge (impossible unless reset), go to IDLE.
  - PREAMBLE → DATA after the last sample of preamble symbol `PREAMBLE_BITS`-1.
  - DATA, at the last sample of bit 0 (8th bit) of a byte:
    - If the shift `last`=1 → GUARD.
    - Else if `hold_v`=1 → load the next byte and continue DATA with no gap.
    - Else → pulse `underrun`, force `data_out`=0, go to IDLE. No guard, no `frame_done`.
  - GUARD → IDLE after `GUARD_SYMBOLS`×`SAMPLES_PER_SYMBOL` cycles. `frame_done`=1 on the first IDLE cycle.
- **`data_out` values by state:**
  - IDLE, SYNC, GUARD: 0.
  - PREAMBLE: `PREAMBLE`[15-`bit_cnt`].
  - DATA: shift register MSB.
- A new frame begins only from IDLE. A byte sitting in the holding register when GUARD ends starts the next frame on the following cycle.
- Reset mid-frame: all state returns to reset values at the next edge, and the held byte is discarded.

## Timing
- All outputs are registered except `s_ready`.
- Reset values:
  - `start`, `data_out`, `sym_strobe`, `busy`, `frame_done`, `underrun`: 0.
  - `hold_v`: 0, so `s_ready` is 1.
  - State: IDLE.
- **Frame timeline** (byte accepted at edge E0):
  - `start` is high in cycle E1..E2.
  - The first preamble symbol starts at edge E1+`SYNC_GAP`, with `sym_strobe`=1.
- Each symbol lasts exactly `SAMPLES_PER_SYMBOL` cycles. `data_out` changes only on symbol boundaries.
- Frame length from `start` to `frame_done`:
  - `SYNC_GAP` + (`PREAMBLE_BITS` + 8·N + `GUARD_SYMBOLS`)·`SAMPLES_PER_SYMBOL` cycles, for N bytes.
  - `frame_done` occurs at the start of the cycle following that span.
- Back-to-back bytes: the next byte must be accepted no later than the last sample of the current byte's bit 0 to avoid underrun.

## Test plan
All scenarios use `SAMPLES_PER_SYMBOL`=4, `SYNC_GAP`=3, `PREAMBLE_BITS`=4, `PREAMBLE`=16'hA000, `GUARD_SYMBOLS`=1.

1. **Reset state:** assert `reset` for 2 cycles → all outputs 0 and `s_ready`=1. Assert `reset` during DATA → next cycle `busy`=0, `data_out`=0, `s_ready`=1.
2. **Single byte:** send 0xC3 with `s_last`=1 at edge E0 → `start` in cycle E1 only. From E4, `data_out` = 1,0,1,0,1,1,0,0,0,0,1,1, each held 4 cycles, with 12 `sym_strobe` pulses. Then 4 cycles of 0. `frame_done` at E56.
3. **Two bytes back-to-back:** 0xFF then 0x01 (`last`), second byte presented while the first transmits → 16 data bits with no gap (8 ones, then 0000_0001). Exactly one `start`, one `frame_done`, no `underrun`.
4. **Underrun:** send 0x80 with `s_last`=0 and no further byte → after bit 0 of 0x80, `underrun` pulses once. `busy`=0, no `frame_done`, `data_out`=0.
5. **Backpressure:** hold `s_valid`=1 with 3 bytes while the framer is busy → `s_ready` deasserts while `hold_v`=1. No byte is lost or duplicated, and the bytes are transmitted in order.
6. **Queued next frame:** with a byte held at GUARD end → `frame_done` pulses, and `start` follows on the next cycle.
